// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch PC stage: BTB entry layout and 2-bit predictor counter encodings.
package fetch_pc_unit_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_WNT   = 2'b01;
   localparam ctr_t CTR_WT    = 2'b10;
   localparam int   TAG_MAX_W = 30;

   // Tag field is sized for the smallest legal BTB; narrower tags are zero-extended.
   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      logic [31:0]          target;
      ctr_t                 ctr;
   } btb_entry_t;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle between the hazard/MEM side (master) and the PC unit (slave).
interface fetch_pc_unit_if;
   logic        pcen;
   logic        halt;
   logic        mem_valid;
   logic        mem_retire;
   logic        mem_is_br;
   logic        mem_is_jmp;
   logic        mem_taken;
   logic [31:0] mem_pc;
   logic [31:0] mem_target;
   logic [31:0] mem_pred_next;
   logic [31:0] imemaddr;
   logic [31:0] if_npc;
   logic [31:0] if_pred_next;
   logic        mispredict;

   modport master (
      output pcen, halt, mem_valid, mem_retire, mem_is_br, mem_is_jmp, mem_taken,
             mem_pc, mem_target, mem_pred_next,
      input  imemaddr, if_npc, if_pred_next, mispredict
   );

   modport slave (
      input  pcen, halt, mem_valid, mem_retire, mem_is_br, mem_is_jmp, mem_taken,
             mem_pc, mem_target, mem_pred_next,
      output imemaddr, if_npc, if_pred_next, mispredict
   );
endinterface

// File: rtl/fetch_pc_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on the pre-update array; updates land at the clock edge.
module branch_target_buffer
   import fetch_pc_unit_pkg::*;
#(
   parameter int BTB_ENTRIES = 16,
   localparam int IDX_W = $clog2(BTB_ENTRIES),
   localparam int TAG_W = 30 - IDX_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IDX_W-1:0] lkup_idx_i,
   input  logic [TAG_W-1:0] lkup_tag_i,
   output logic             lkup_taken_o,
   output logic [31:0]      lkup_target_o,
   input  logic             upd_en_i,
   input  logic             upd_taken_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic [TAG_W-1:0] upd_tag_i,
   input  logic [31:0]      upd_target_i
);

   btb_entry_t entries_q [BTB_ENTRIES];
   btb_entry_t lkup_ent;
   btb_entry_t upd_ent;
   logic       upd_hit;

   function automatic logic [TAG_MAX_W-1:0] pad_tag(input logic [TAG_W-1:0] t);
      logic [TAG_MAX_W-1:0] r;
      r          = '0;
      r[TAG_W-1:0] = t;
      return r;
   endfunction

   function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
      if (taken) return (c == 2'b11) ? c : c + 2'd1;
      else       return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   assign lkup_ent      = entries_q[lkup_idx_i];
   assign lkup_taken_o  = lkup_ent.valid & (lkup_ent.tag == pad_tag(lkup_tag_i)) & lkup_ent.ctr[1];
   assign lkup_target_o = lkup_ent.target;

   assign upd_ent = entries_q[upd_idx_i];
   assign upd_hit = upd_ent.valid & (upd_ent.tag == pad_tag(upd_tag_i));

   // Only valid and counter need a known reset value; tag/target are qualified by valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            entries_q[i].valid <= 1'b0;
            entries_q[i].ctr   <= CTR_WNT;
         end
      end else if (upd_en_i) begin
         if (upd_hit) begin
            entries_q[upd_idx_i].ctr <= ctr_step(upd_ent.ctr, upd_taken_i);
            if (upd_taken_i) entries_q[upd_idx_i].target <= upd_target_i;
         end else if (upd_taken_i) begin
            entries_q[upd_idx_i].valid  <= 1'b1;
            entries_q[upd_idx_i].tag    <= pad_tag(upd_tag_i);
            entries_q[upd_idx_i].target <= upd_target_i;
            entries_q[upd_idx_i].ctr    <= CTR_WT;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program-counter stage: BTB-predicted next PC, MEM-stage misprediction detection and redirect,
// hazard-unit stall gating and a sticky halt that freezes fetch until reset.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] PC_INIT     = 32'h0,
   parameter int          BTB_ENTRIES = 16
) (
   input logic           CLK,
   input logic           RST,
   fetch_pc_unit_if.slave bus
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [31:0] pc_q, pc_d;
   logic        halted_q, halted_d;
   logic [31:0] npc, actual_next, pred_next, btb_target;
   logic        btb_taken, res_taken, misp, upd_en;

   assign npc         = pc_plus4(pc_q);
   assign res_taken   = bus.mem_is_jmp | (bus.mem_is_br & bus.mem_taken);
   assign actual_next = res_taken ? bus.mem_target : pc_plus4(bus.mem_pc);
   // Also catches non-branches that were predicted taken (aliasing): they resolve to mem_pc+4.
   assign misp        = bus.mem_valid & ~halted_q & (actual_next != bus.mem_pred_next);
   assign pred_next   = btb_taken ? btb_target : npc;
   assign upd_en      = bus.mem_retire & bus.mem_valid & (bus.mem_is_br | bus.mem_is_jmp) & ~halted_q;

   branch_target_buffer #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
      .clk_i         (CLK),
      .rst_i         (RST),
      .lkup_idx_i    (pc_q[IDX_W+1:2]),
      .lkup_tag_i    (pc_q[31:IDX_W+2]),
      .lkup_taken_o  (btb_taken),
      .lkup_target_o (btb_target),
      .upd_en_i      (upd_en),
      .upd_taken_i   (res_taken),
      .upd_idx_i     (bus.mem_pc[IDX_W+1:2]),
      .upd_tag_i     (bus.mem_pc[31:IDX_W+2]),
      .upd_target_i  (bus.mem_target)
   );

   always_comb begin
      pc_d     = pc_q;
      halted_d = halted_q | bus.halt;
      if (bus.pcen & ~bus.halt & ~halted_q) begin
         pc_d = misp ? actual_next : pred_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q     <= PC_INIT;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   assign bus.imemaddr     = pc_q;
   assign bus.if_npc       = npc;
   assign bus.if_pred_next = pred_next;
   assign bus.mispredict   = misp;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_pc_unit;
   import fetch_pc_unit_pkg::*;

   localparam int NE    = 16;
   localparam int SHIFT = 6;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   fetch_pc_unit_if bus();

   fetch_pc_unit #(.PC_INIT(32'h0), .BTB_ENTRIES(NE)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [31:0] m_pc;
   bit          m_halted;
   bit          m_valid [NE];
   logic [31:0] m_tag   [NE];
   logic [31:0] m_tgt   [NE];
   int          m_ctr   [NE];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      else n_pass++;
   endtask

   function automatic void m_reset();
      m_pc     = 32'h0;
      m_halted = 0;
      for (int i = 0; i < NE; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 1;
      end
   endfunction

   function automatic void m_eval(output logic [31:0] pred, output bit misp, output logic [31:0] act);
      int i = int'((m_pc >> 2) % NE);
      pred = (m_valid[i] && m_tag[i] == (m_pc >> SHIFT) && m_ctr[i] >= 2) ? m_tgt[i] : m_pc + 32'd4;
      act  = (bus.mem_is_jmp || (bus.mem_is_br && bus.mem_taken)) ? bus.mem_target : bus.mem_pc + 32'd4;
      misp = bus.mem_valid && !m_halted && (act != bus.mem_pred_next);
   endfunction

   // Check outputs against the model, then advance the model and the DUT by one clock.
   task automatic tick();
      logic [31:0] pn, an;
      bit          mp, tk;
      int          i;
      #1;
      m_eval(pn, mp, an);
      chk("imemaddr", bus.imemaddr, m_pc);
      chk("if_npc", bus.if_npc, m_pc + 32'd4);
      chk("if_pred_next", bus.if_pred_next, pn);
      chk("mispredict", {31'b0, bus.mispredict}, {31'b0, mp});
      if (rst) m_reset();
      else begin
         if (bus.pcen && !bus.halt && !m_halted) m_pc = mp ? an : pn;
         if (bus.mem_retire && bus.mem_valid && (bus.mem_is_br || bus.mem_is_jmp) && !m_halted) begin
            tk = bus.mem_is_jmp || bus.mem_taken;
            i  = int'((bus.mem_pc >> 2) % NE);
            if (m_valid[i] && m_tag[i] == (bus.mem_pc >> SHIFT)) begin
               m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
               if (tk) m_tgt[i] = bus.mem_target;
            end else if (tk) begin
               m_valid[i] = 1;
               m_tag[i]   = bus.mem_pc >> SHIFT;
               m_tgt[i]   = bus.mem_target;
               m_ctr[i]   = 2;
            end
         end
         if (bus.halt) m_halted = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input bit v, input bit ret, input bit br, input bit jmp, input bit tk,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pred);
      bus.mem_valid     = v;
      bus.mem_retire    = ret;
      bus.mem_is_br     = br;
      bus.mem_is_jmp    = jmp;
      bus.mem_taken     = tk;
      bus.mem_pc        = pc;
      bus.mem_target    = tgt;
      bus.mem_pred_next = pred;
   endtask

   task automatic idle_mem();
      set_mem(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
   endtask

   // Force the fetch PC to 'dst' via a non-retiring jump mispredict (no BTB change).
   task automatic redirect(input logic [31:0] dst);
      bus.pcen = 1;
      set_mem(1, 0, 0, 1, 0, 32'h300, dst, 32'h304);
      tick();
      idle_mem();
   endtask

   logic [31:0] pool [6];
   int          sel;

   initial begin
      pool = '{32'h20, 32'h24, 32'h420, 32'h60, 32'h3c, 32'h80};
      rst      = 1;
      bus.pcen = 0;
      bus.halt = 0;
      idle_mem();
      m_reset();
      @(posedge clk);
      #1;
      rst = 0;

      // Reset state and sequential fetch
      chk("rst_imemaddr", bus.imemaddr, 32'h0);
      chk("rst_pred", bus.if_pred_next, 32'h4);
      chk("rst_misp", {31'b0, bus.mispredict}, 32'h0);
      bus.pcen = 1;
      repeat (3) tick();
      chk("seq_pc12", bus.imemaddr, 32'hc);
      tick();

      // Stall
      bus.pcen = 0;
      repeat (5) tick();
      chk("stall_hold", bus.imemaddr, 32'h10);
      bus.pcen = 1;
      tick();
      chk("stall_release", bus.imemaddr, 32'h14);

      // Cold taken branch
      set_mem(1, 1, 1, 0, 1, 32'h20, 32'h40, 32'h24);
      #1 chk("cold_misp", {31'b0, bus.mispredict}, 32'h1);
      tick();
      chk("cold_redirect", bus.imemaddr, 32'h40);
      idle_mem();
      redirect(32'h20);
      chk("cold_learned", bus.if_pred_next, 32'h40);

      // Counter hysteresis
      repeat (2) begin
         set_mem(1, 1, 1, 0, 1, 32'h20, 32'h40, 32'h40);
         tick();
      end
      set_mem(1, 1, 1, 0, 0, 32'h20, 32'h40, 32'h40);
      tick();
      chk("hyst_nt1_pc", bus.imemaddr, 32'h24);
      idle_mem();
      redirect(32'h20);
      chk("hyst_nt1_pred", bus.if_pred_next, 32'h40);
      set_mem(1, 1, 1, 0, 0, 32'h20, 32'h40, 32'h40);
      tick();
      idle_mem();
      redirect(32'h20);
      chk("hyst_nt2_pred", bus.if_pred_next, 32'h24);

      // Redirect under stall
      bus.pcen = 0;
      set_mem(1, 0, 0, 1, 0, 32'h30, 32'h60, 32'h34);
      repeat (3) tick();
      chk("stall_redir_hold", bus.imemaddr, 32'h20);
      chk("stall_redir_misp", {31'b0, bus.mispredict}, 32'h1);
      bus.pcen = 1;
      tick();
      chk("stall_redir_go", bus.imemaddr, 32'h60);
      idle_mem();

      // Halt freezes PC/BTB; reset clears
      redirect(32'h80);
      bus.halt = 1;
      tick();
      bus.halt = 0;
      set_mem(1, 1, 1, 0, 1, 32'h80, 32'h200, 32'h84);
      repeat (3) tick();
      chk("halt_pc", bus.imemaddr, 32'h80);
      chk("halt_misp", {31'b0, bus.mispredict}, 32'h0);
      chk("halt_btb", bus.if_pred_next, 32'h84);
      idle_mem();
      rst = 1;
      tick();
      rst = 0;
      chk("halt_rst_pc", bus.imemaddr, 32'h0);
      redirect(32'h20);
      chk("rst_btb_clear", bus.if_pred_next, 32'h24);

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         rst            = ($urandom_range(0, 59) == 0);
         bus.halt       = ($urandom_range(0, 99) == 0);
         bus.pcen       = ($urandom_range(0, 3) != 0);
         bus.mem_valid  = ($urandom_range(0, 9) < 7);
         bus.mem_retire = bus.pcen && ($urandom_range(0, 3) != 0);
         sel            = $urandom_range(0, 3);
         bus.mem_is_br  = (sel == 1 || sel == 3);
         bus.mem_is_jmp = (sel == 2);
         bus.mem_taken  = 1'($urandom_range(0, 1));
         bus.mem_pc     = ($urandom_range(0, 4) == 0) ? {22'b0, 8'($urandom), 2'b00} : pool[$urandom_range(0, 5)];
         bus.mem_target = {22'b0, 8'($urandom), 2'($urandom_range(0, 7) == 0 ? $urandom : 0)};
         sel            = $urandom_range(0, 2);
         bus.mem_pred_next = (sel == 0) ? bus.mem_pc + 32'd4 : (sel == 1) ? bus.mem_target : $urandom;
         tick();
      end
      rst = 0;
      bus.halt = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
